// File: rtl/tbird_signal_sequencer.sv
// Thunderbird tail-lamp sequencer: arbitrates turn/hazard/brake requests and
// paces the lamp sequence with a tick prescaler. All outputs are registered.
module tbird_signal_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic Lc,
    output logic Lb,
    output logic La,
    output logic Ra,
    output logic Rb,
    output logic Rc,
    output logic busy,
    output logic haz_active
);

    localparam int CW = $clog2(TICK_DIV + 1);

    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, HON, HOFF
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_arb;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_tick;
    logic            w_haz_req;
    logic [5:0]      w_lamps;      // {Lc,Lb,La,Ra,Rb,Rc}
    logic [5:0]      r_lamps;
    logic            r_busy;
    logic            r_haz_active;

    assign w_haz_req = hazard | (left & right);
    assign w_tick    = (r_state != IDLE) && (r_cnt == CW'(TICK_DIV - 1));

    always_comb begin
        if (w_haz_req)  w_arb = HON;
        else if (left)  w_arb = L1;
        else if (right) w_arb = R1;
        else            w_arb = IDLE;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_arb;
            L1:      if (w_tick) w_next = w_haz_req ? HON : L2;
            L2:      if (w_tick) w_next = w_haz_req ? HON : L3;
            L3:      if (w_tick) w_next = w_haz_req ? HON : LOFF;
            R1:      if (w_tick) w_next = w_haz_req ? HON : R2;
            R2:      if (w_tick) w_next = w_haz_req ? HON : R3;
            R3:      if (w_tick) w_next = w_haz_req ? HON : ROFF;
            LOFF,
            ROFF,
            HOFF:    if (w_tick) w_next = w_arb;
            HON:     if (w_tick) w_next = HOFF;
            default: w_next = IDLE;
        endcase
    end

    // Every tick changes state, so one clear condition covers both cases.
    always_comb begin
        w_cnt_next = r_cnt + CW'(1);
        if (r_state == IDLE || w_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    // Decode from next-state so the lamps load on the same edge as the state.
    always_comb begin
        w_lamps = 6'b000_000;
        case (w_next)
            L1:      w_lamps = 6'b001_000;
            L2:      w_lamps = 6'b011_000;
            L3:      w_lamps = 6'b111_000;
            R1:      w_lamps = 6'b000_100;
            R2:      w_lamps = 6'b000_110;
            R3:      w_lamps = 6'b000_111;
            HON:     w_lamps = 6'b111_111;
            default: w_lamps = 6'b000_000;
        endcase
        if (brake) begin
            case (w_next)
                IDLE:                w_lamps      = 6'b111_111;
                L1, L2, L3, LOFF:    w_lamps[2:0] = 3'b111;
                R1, R2, R3, ROFF:    w_lamps[5:3] = 3'b111;
                default:             ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_lamps      <= '0;
            r_busy       <= 1'b0;
            r_haz_active <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_lamps      <= w_lamps;
            r_busy       <= (w_next != IDLE);
            r_haz_active <= (w_next == HON) || (w_next == HOFF);
        end
    end

    assign {Lc, Lb, La, Ra, Rb, Rc} = r_lamps;
    assign busy       = r_busy;
    assign haz_active = r_haz_active;

endmodule
